// File: rtl/uart_link.sv
// 8N1 UART endpoint: synchronised RX deserialiser with a byte handshake, plus an
// independent TX serialiser. Both engines run on clk with a synchronous reset.
module uart_link #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       tx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  input  logic       tx_send,
  input  logic [7:0] tx_byte,
  output logic       tx_ready
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = 4;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(7);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // RX state
  logic          rx_sync1, rx_sync2;
  state_t        rx_state, rx_state_nxt;
  logic [CW-1:0] rx_cnt, rx_cnt_nxt;
  logic [BW-1:0] rx_bit, rx_bit_nxt;
  logic [7:0]    rx_shift, rx_shift_nxt;
  logic          rx_valid_nxt;
  logic [7:0]    rx_byte_nxt;
  logic          rx_overrun_nxt, rx_frame_err_nxt;

  // TX state
  state_t        tx_state, tx_state_nxt;
  logic [CW-1:0] tx_cnt, tx_cnt_nxt;
  logic [BW-1:0] tx_bit, tx_bit_nxt;
  logic [7:0]    tx_shift, tx_shift_nxt;
  logic          tx_nxt, tx_ready_nxt;

  // State and output registers for both engines
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync1     <= 1'b1;
      rx_sync2     <= 1'b1;
      rx_state     <= S_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_valid     <= 1'b0;
      rx_byte      <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      tx_state     <= S_IDLE;
      tx_cnt       <= '0;
      tx_bit       <= '0;
      tx_shift     <= '0;
      tx           <= 1'b1;
      tx_ready     <= 1'b1;
    end else begin
      rx_sync1     <= rx;
      rx_sync2     <= rx_sync1;
      rx_state     <= rx_state_nxt;
      rx_cnt       <= rx_cnt_nxt;
      rx_bit       <= rx_bit_nxt;
      rx_shift     <= rx_shift_nxt;
      rx_valid     <= rx_valid_nxt;
      rx_byte      <= rx_byte_nxt;
      rx_overrun   <= rx_overrun_nxt;
      rx_frame_err <= rx_frame_err_nxt;
      tx_state     <= tx_state_nxt;
      tx_cnt       <= tx_cnt_nxt;
      tx_bit       <= tx_bit_nxt;
      tx_shift     <= tx_shift_nxt;
      tx           <= tx_nxt;
      tx_ready     <= tx_ready_nxt;
    end
  end

  // RX next state: mid-bit sampling plus consumer handshake
  always_comb begin
    rx_state_nxt     = rx_state;
    rx_cnt_nxt       = rx_cnt;
    rx_bit_nxt       = rx_bit;
    rx_shift_nxt     = rx_shift;
    rx_valid_nxt     = rx_valid;
    rx_byte_nxt      = rx_byte;
    rx_overrun_nxt   = 1'b0;
    rx_frame_err_nxt = 1'b0;

    if (rx_ack && rx_valid) rx_valid_nxt = 1'b0;

    case (rx_state)
      S_IDLE: begin
        rx_cnt_nxt = '0;
        rx_bit_nxt = '0;
        if (!rx_sync2) rx_state_nxt = S_START;
      end
      S_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = rx_sync2 ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_nxt = rx_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_sync2, rx_shift[7:1]};
          if (rx_bit == LAST_DATA) begin
            rx_bit_nxt   = '0;
            rx_state_nxt = S_STOP;
          end else begin
            rx_bit_nxt = rx_bit + BW'(1);
          end
        end else begin
          rx_cnt_nxt = rx_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = S_IDLE;
          if (!rx_sync2) begin
            rx_frame_err_nxt = 1'b1;
          end else if (!rx_valid || rx_ack) begin
            // a same-edge ack frees the slot for the new byte
            rx_byte_nxt  = rx_shift;
            rx_valid_nxt = 1'b1;
          end else begin
            rx_overrun_nxt = 1'b1;
          end
        end else begin
          rx_cnt_nxt = rx_cnt + CW'(1);
        end
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  // TX next state: start, 8 data bits LSB first, stop, each one bit period
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_nxt       = tx;
    tx_ready_nxt = tx_ready;

    case (tx_state)
      S_IDLE: begin
        tx_cnt_nxt   = '0;
        tx_bit_nxt   = '0;
        tx_nxt       = 1'b1;
        tx_ready_nxt = 1'b1;
        if (tx_send && tx_ready) begin
          tx_shift_nxt = tx_byte;
          tx_state_nxt = S_START;
          tx_nxt       = 1'b0;
          tx_ready_nxt = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_state_nxt = S_DATA;
          tx_nxt       = tx_shift[0];
        end else begin
          tx_cnt_nxt = tx_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt = '0;
          if (tx_bit == LAST_DATA) begin
            tx_bit_nxt   = '0;
            tx_state_nxt = S_STOP;
            tx_nxt       = 1'b1;
          end else begin
            tx_bit_nxt   = tx_bit + BW'(1);
            tx_shift_nxt = {1'b1, tx_shift[7:1]};
            tx_nxt       = tx_shift[1];
          end
        end else begin
          tx_cnt_nxt = tx_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_state_nxt = S_IDLE;
          tx_ready_nxt = 1'b1;
        end else begin
          tx_cnt_nxt = tx_cnt + CW'(1);
        end
      end
      default: tx_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_link.sv
// Directed bench for uart_link: frame-level reference model checked every cycle,
// plus literal expectations for the TX waveform and the RX handshake cases.
module tb_uart_link;
  localparam int CPB = 8;
  // edges from the first edge that sees rx low to the result: 9.5 bit periods + 2-flop sync
  localparam int RX_LAT = 78;

  logic       clk = 1'b0;
  logic       reset, rx_line, loopback, rx_pin, tx;
  logic       rx_valid, rx_ack, rx_overrun, rx_frame_err;
  logic       tx_send, tx_ready;
  logic [7:0] rx_byte, tx_byte;

  always #5 clk = ~clk;
  assign rx_pin = loopback ? tx : rx_line;

  uart_link #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx_pin), .tx(tx),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ack(rx_ack),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
    .tx_send(tx_send), .tx_byte(tx_byte), .tx_ready(tx_ready)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         due;
    logic [7:0] b;
    logic       ok;
  } rx_ev_t;

  rx_ev_t     rxq[$];
  int         cyc = 0;
  int         ovr_seen = 0;
  int         ferr_seen = 0;

  // Expected serial level t cycles into a frame carrying b
  function automatic logic frame_bit(input logic [7:0] b, input int t);
    int k;
    k = t / CPB;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  // Reference model, advanced once per edge, then compared to the DUT 1 time unit later
  initial begin
    logic       m_busy, m_valid, m_ovr, m_ferr, ack_take;
    logic       s_reset, s_send, s_ack, s_loop;
    logic [7:0] m_tb, m_byte, s_byte;
    int         m_t;
    rx_ev_t     ev;
    m_busy = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    m_tb = '0; m_byte = '0; m_t = 0;
    forever begin
      @(posedge clk);
      s_reset = reset; s_send = tx_send; s_ack = rx_ack; s_loop = loopback; s_byte = tx_byte;
      cyc++;
      if (s_reset) begin
        m_busy = 1'b0; m_valid = 1'b0; m_byte = '0; m_ovr = 1'b0; m_ferr = 1'b0;
        rxq.delete();
      end else begin
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        ack_take = s_ack && m_valid;
        if (rxq.size() > 0 && rxq[0].due == cyc) begin
          ev = rxq.pop_front();
          if (!ev.ok) m_ferr = 1'b1;
          else if (!m_valid || s_ack) begin
            m_byte = ev.b; m_valid = 1'b1; ack_take = 1'b0;
          end else m_ovr = 1'b1;
        end
        if (ack_take) m_valid = 1'b0;
        if (m_busy) begin
          m_t++;
          if (m_t == 10 * CPB) m_busy = 1'b0;
        end else if (s_send) begin
          m_busy = 1'b1; m_t = 0; m_tb = s_byte;
          if (s_loop) rxq.push_back('{due: cyc + 1 + RX_LAT, b: s_byte, ok: 1'b1});
        end
      end
      #1;
      check("tx", 32'(tx), 32'(m_busy ? frame_bit(m_tb, m_t) : 1'b1));
      check("tx_ready", 32'(tx_ready), 32'(!m_busy));
      check("rx_valid", 32'(rx_valid), 32'(m_valid));
      check("rx_byte", 32'(rx_byte), 32'(m_byte));
      check("rx_overrun", 32'(rx_overrun), 32'(m_ovr));
      check("rx_frame_err", 32'(rx_frame_err), 32'(m_ferr));
      if (rx_overrun === 1'b1) ovr_seen++;
      if (rx_frame_err === 1'b1) ferr_seen++;
    end
  end

  // Drive one 8N1 frame on rx followed by 16 idle cycles
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(negedge clk);
    rxq.push_back('{due: cyc + 1 + RX_LAT, b: b, ok: stop});
    for (int i = 0; i < 10; i++) begin
      rx_line = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic rx_ack_pulse();
    @(negedge clk) rx_ack = 1'b1;
    @(negedge clk) rx_ack = 1'b0;
    check("rx_valid_after_ack", 32'(rx_valid), 32'd0);
  endtask

  // Send one byte and check mid-bit levels against a literal frame image
  task automatic tx_capture(input logic [7:0] b, input logic [9:0] expf);
    int low;
    @(negedge clk) begin tx_byte = b; tx_send = 1'b1; end
    @(negedge clk) tx_send = 1'b0;
    low = 0;
    for (int t = 0; t < 100; t++) begin
      if (tx_ready !== 1'b1) low++;
      if (t < 80 && t % CPB == CPB / 2)
        check($sformatf("tx_frame_bit%0d", t / CPB), 32'(tx), 32'(expf[t / CPB]));
      @(negedge clk);
    end
    check("tx_busy_len", 32'(low), 32'd80);
  endtask

  initial begin
    int o0, f0, falls;
    logic prev;
    reset = 1'b1; rx_line = 1'b1; loopback = 1'b0; rx_ack = 1'b0;
    tx_send = 1'b0; tx_byte = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_byte", 32'(rx_byte), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // TX frame 0x45: start, 1,0,1,0,0,0,1,0, stop
    tx_capture(8'h45, 10'b1_0100_0101_0);

    // RX with handshake, then a second clean frame
    rx_frame(8'h65, 1'b1);
    check("rx1_valid", 32'(rx_valid), 32'd1);
    check("rx1_byte", 32'(rx_byte), 32'h65);
    rx_ack_pulse();
    rx_frame(8'h45, 1'b1);
    check("rx2_valid", 32'(rx_valid), 32'd1);
    check("rx2_byte", 32'(rx_byte), 32'h45);
    rx_ack_pulse();

    // Overrun: second frame lands while the first is pending
    o0 = ovr_seen; f0 = ferr_seen;
    rx_frame(8'h72, 1'b1);
    rx_frame(8'h52, 1'b1);
    check("ovr_byte_kept", 32'(rx_byte), 32'h72);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_pulses", 32'(ovr_seen - o0), 32'd1);
    check("ovr_no_ferr", 32'(ferr_seen - f0), 32'd0);
    rx_ack_pulse();

    // Framing error, then a 2-cycle glitch
    f0 = ferr_seen;
    rx_frame(8'h52, 1'b0);
    check("ferr_valid", 32'(rx_valid), 32'd0);
    check("ferr_pulses", 32'(ferr_seen - f0), 32'd1);
    f0 = ferr_seen;
    @(negedge clk) rx_line = 1'b0;
    repeat (2) @(negedge clk);
    rx_line = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_valid", 32'(rx_valid), 32'd0);
    check("glitch_ferr", 32'(ferr_seen - f0), 32'd0);

    // Reset in the middle of TX data bit 3, then a clean frame
    @(negedge clk) begin tx_byte = 8'h33; tx_send = 1'b1; end
    @(negedge clk) tx_send = 1'b0;
    repeat (36) @(negedge clk);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_tx_ready", 32'(tx_ready), 32'd1);
    tx_capture(8'h4F, 10'b1_0100_1111_0);

    // Loopback 0x21 with held and repeated tx_send during the busy window
    loopback = 1'b1;
    falls = 0;
    prev = tx_ready;
    @(negedge clk) begin tx_byte = 8'h21; tx_send = 1'b1; end
    for (int t = 0; t < 140; t++) begin
      @(negedge clk);
      if (t == 2) tx_send = 1'b0;
      if (t == 30) begin tx_send = 1'b1; tx_byte = 8'hFF; end
      if (t == 31) tx_send = 1'b0;
      if (prev === 1'b1 && tx_ready === 1'b0) falls++;
      prev = tx_ready;
    end
    check("loop_frames", 32'(falls), 32'd1);
    check("loop_valid", 32'(rx_valid), 32'd1);
    check("loop_byte", 32'(rx_byte), 32'h21);
    loopback = 1'b0;
    rx_ack_pulse();
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
